// File: rtl/game_pkg.sv
// Shared types and helpers for the game flow controller.
//   state_t      : top-level game flow states
//   SCR_*        : fixed screen indices for the non-level screens
//   thermometer  : lives count to 10-bit LED thermometer
package game_pkg;

   typedef enum logic [2:0] {
      StStart,
      StHold,
      StPlay,
      StWin,
      StGameOver
   } state_t;

   localparam logic [2:0] SCR_START     = 3'd0;
   localparam logic [2:0] SCR_WIN       = 3'd6;
   localparam logic [2:0] SCR_GAME_OVER = 3'd7;

   // leds[k] = 1 iff k < n
   function automatic logic [9:0] thermometer(input logic [2:0] n);
      logic [9:0] t;
      t = '0;
      for (int k = 0; k < 10; k++) begin
         t[k] = (k < int'(n));
      end
      return t;
   endfunction

endpackage

// File: rtl/button_press_sync.sv
// Two-flop synchronizer plus one-cycle falling-edge detector for a raw,
// active-low push button.
//   clk_i   : sampling clock
//   rst_i   : asynchronous active-high reset
//   btn_ni  : raw active-low button, asynchronous to clk_i
//   press_o : one-cycle pulse on each 1->0 edge of the synchronized button
module button_press_sync #(
   parameter logic ResetLevel = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_ni,
   output logic press_o
);

   logic sync1_q, sync2_q, prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= ResetLevel;
         sync2_q <= ResetLevel;
         prev_q  <= ResetLevel;
      end else begin
         sync1_q <= btn_ni;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Held button keeps sync2_q low, so prev_q follows and the pulse ends.
   assign press_o = prev_q & ~sync2_q;

endmodule

// File: rtl/game_flow_controller.sv
// Whole-game sequencer: screen select, per-level reset/run gating, lives
// and per-attempt countdown timer.
//   vga_clock     : sole clock
//   reset         : asynchronous active-high reset
//   start_button  : raw active-low start button
//   level_win     : per-level win flags (bit i = level i+1), used in PLAY only
//   level_lose    : per-level lose flags (bit i = level i+1), used in PLAY only
//   screen        : 0 start, 1..NUM_LEVELS level, 6 win, 7 game over
//   level_reset_n : active-low reset for the selected screen module
//   inputs_enable : high only while a level is being played
//   lives         : remaining lives
//   seconds       : remaining seconds of the current attempt
//   leds          : lives thermometer
module game_flow_controller
   import game_pkg::*;
#(
   parameter int unsigned NUM_LEVELS        = 3,
   parameter int unsigned START_LIVES       = 3,
   parameter int unsigned TIME_LIMIT        = 100,
   parameter int unsigned CLOCKS_PER_SECOND = 25_000_000,
   parameter int unsigned HOLD_CYCLES       = 50_000_000
) (
   input  logic                  vga_clock,
   input  logic                  reset,
   input  logic                  start_button,
   input  logic [NUM_LEVELS-1:0] level_win,
   input  logic [NUM_LEVELS-1:0] level_lose,
   output logic [2:0]            screen,
   output logic                  level_reset_n,
   output logic                  inputs_enable,
   output logic [2:0]            lives,
   output logic [31:0]           seconds,
   output logic [9:0]            leds
);

   localparam logic [31:0] HoldLoad = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] TickLast = 32'(CLOCKS_PER_SECOND - 1);
   localparam logic [31:0] TimeInit = 32'(TIME_LIMIT);
   localparam logic [2:0]  LivesInit = 3'(START_LIVES);
   localparam logic [2:0]  LastLevel = 3'(NUM_LEVELS);

   logic press;

   button_press_sync #(
      .ResetLevel(1'b1)
   ) u_start_sync (
      .clk_i  (vga_clock),
      .rst_i  (reset),
      .btn_ni (start_button),
      .press_o(press)
   );

   state_t      state_q, state_d;
   logic [2:0]  level_q, level_d;
   logic [2:0]  lives_q, lives_d;
   logic [31:0] seconds_q, seconds_d;
   logic [31:0] tick_q, tick_d;
   logic [31:0] hold_q, hold_d;

   logic [2:0]  screen_q;
   logic        lvl_rst_n_q;
   logic        in_en_q;
   logic [9:0]  leds_q;

   // Only the flag for the current level counts.
   logic [NUM_LEVELS-1:0] cur_mask;
   logic                  win_hit, lose_hit;
   assign cur_mask = NUM_LEVELS'(1) << (level_q - 3'd1);
   assign win_hit  = |(level_win & cur_mask);
   assign lose_hit = |(level_lose & cur_mask) || (seconds_q == '0);

   always_ff @(posedge vga_clock or posedge reset) begin
      if (reset) begin
         state_q   <= StStart;
         level_q   <= 3'd1;
         lives_q   <= LivesInit;
         seconds_q <= TimeInit;
         tick_q    <= '0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         level_q   <= level_d;
         lives_q   <= lives_d;
         seconds_q <= seconds_d;
         tick_q    <= tick_d;
         hold_q    <= hold_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      lives_d   = lives_q;
      seconds_d = seconds_q;
      tick_d    = tick_q;
      hold_d    = hold_q;
      unique case (state_q)
         StStart: begin
            if (press) begin
               state_d = StHold;
               level_d = 3'd1;
               lives_d = LivesInit;
               hold_d  = HoldLoad;
            end
         end
         StHold: begin
            if (hold_q == '0) begin
               state_d   = StPlay;
               seconds_d = TimeInit;
               tick_d    = '0;
            end else begin
               hold_d = hold_q - 32'd1;
            end
         end
         StPlay: begin
            if (win_hit) begin
               if (level_q == LastLevel) begin
                  state_d = StWin;
               end else begin
                  state_d = StHold;
                  level_d = level_q + 3'd1;
                  hold_d  = HoldLoad;
               end
            end else if (lose_hit) begin
               lives_d = lives_q - 3'd1;
               if (lives_q == 3'd1) begin
                  state_d = StGameOver;
               end else begin
                  state_d = StHold;
                  hold_d  = HoldLoad;
               end
            end else if (tick_q == TickLast) begin
               tick_d = '0;
               if (seconds_q != '0) seconds_d = seconds_q - 32'd1;
            end else begin
               tick_d = tick_q + 32'd1;
            end
         end
         StWin, StGameOver: begin
            if (press) state_d = StStart;
         end
         default: state_d = StStart;
      endcase
   end

   // Outputs registered from next-state so they move with the state change.
   always_ff @(posedge vga_clock or posedge reset) begin
      if (reset) begin
         screen_q    <= SCR_START;
         lvl_rst_n_q <= 1'b0;
         in_en_q     <= 1'b0;
         leds_q      <= thermometer(LivesInit);
      end else begin
         unique case (state_d)
            StHold, StPlay: screen_q <= level_d;
            StWin:          screen_q <= SCR_WIN;
            StGameOver:     screen_q <= SCR_GAME_OVER;
            default:        screen_q <= SCR_START;
         endcase
         lvl_rst_n_q <= (state_d == StPlay) || (state_d == StWin) || (state_d == StGameOver);
         in_en_q     <= (state_d == StPlay);
         leds_q      <= thermometer(lives_d);
      end
   end

   assign screen        = screen_q;
   assign level_reset_n = lvl_rst_n_q;
   assign inputs_enable = in_en_q;
   assign lives         = lives_q;
   assign seconds       = seconds_q;
   assign leds          = leds_q;

endmodule

// File: tb/tb_game_flow_controller.sv
module tb_game_flow_controller;

   logic        vga_clock = 1'b0;
   logic        reset;
   logic        start_button;
   logic [2:0]  level_win;
   logic [2:0]  level_lose;
   logic [2:0]  screen;
   logic        level_reset_n;
   logic        inputs_enable;
   logic [2:0]  lives;
   logic [31:0] seconds;
   logic [9:0]  leds;

   int checks   = 0;
   int failures = 0;
   int n;

   game_flow_controller #(
      .NUM_LEVELS       (3),
      .START_LIVES      (2),
      .TIME_LIMIT       (2),
      .CLOCKS_PER_SECOND(4),
      .HOLD_CYCLES      (3)
   ) dut (
      .vga_clock    (vga_clock),
      .reset        (reset),
      .start_button (start_button),
      .level_win    (level_win),
      .level_lose   (level_lose),
      .screen       (screen),
      .level_reset_n(level_reset_n),
      .inputs_enable(inputs_enable),
      .lives        (lives),
      .seconds      (seconds),
      .leds         (leds)
   );

   always #5 vga_clock = ~vga_clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(negedge vga_clock);
   endtask

   // Called on the first HOLD cycle; returns HOLD length in cycles.
   task automatic measure_hold(output int len);
      len = 0;
      while (level_reset_n == 1'b0 && len < 10) begin
         len++;
         step(1);
      end
   endtask

   task automatic do_press();
      start_button = 1'b0;
      step(3);
      start_button = 1'b1;
   endtask

   task automatic win_step(input logic [2:0] bits);
      level_win = bits;
      step(1);
      level_win = 3'b000;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      start_button = 1'b1;
      level_win    = '0;
      level_lose   = '0;
      #2;
      check("rst_screen", 32'(screen), 32'd0);
      check("rst_lrn", 32'(level_reset_n), 32'd0);
      check("rst_inen", 32'(inputs_enable), 32'd0);
      check("rst_lives", 32'(lives), 32'd2);
      check("rst_seconds", seconds, 32'd2);
      check("rst_leds", 32'(leds), 32'h3);
      step(1);
      reset = 1'b0;
      step(2);
      check("idle_screen", 32'(screen), 32'd0);

      // Start press held for 20 cycles.
      start_button = 1'b0;
      n = 0;
      while (screen != 3'd1 && n < 8) begin
         step(1);
         n++;
      end
      check("start_latency", 32'(n), 32'd3);
      check("hold1_lrn", 32'(level_reset_n), 32'd0);
      measure_hold(n);
      check("hold1_len", 32'(n), 32'd3);
      check("play1_lrn", 32'(level_reset_n), 32'd1);
      check("play1_inen", 32'(inputs_enable), 32'd1);
      check("play1_screen", 32'(screen), 32'd1);
      check("play1_sec", seconds, 32'd2);

      // Timeout path.
      step(3);
      check("sec_before_tick", seconds, 32'd2);
      step(1);
      check("sec_1", seconds, 32'd1);
      step(4);
      check("sec_0", seconds, 32'd0);
      check("sec_0_screen", 32'(screen), 32'd1);
      step(1);
      check("tmo_lives", 32'(lives), 32'd1);
      check("tmo_leds", 32'(leds), 32'h1);
      check("tmo_screen", 32'(screen), 32'd1);
      check("tmo_lrn", 32'(level_reset_n), 32'd0);
      measure_hold(n);
      check("hold_retry_len", 32'(n), 32'd3);
      check("retry_sec", seconds, 32'd2);
      step(2);
      start_button = 1'b1;
      step(2);

      // Second loss ends the game.
      level_lose = 3'b001;
      step(1);
      level_lose = 3'b000;
      check("go_screen", 32'(screen), 32'd7);
      check("go_lives", 32'(lives), 32'd0);
      check("go_leds", 32'(leds), 32'h0);
      check("go_lrn", 32'(level_reset_n), 32'd1);
      check("go_inen", 32'(inputs_enable), 32'd0);

      // Held press in GAME_OVER: one press only.
      start_button = 1'b0;
      step(2);
      check("go_wait", 32'(screen), 32'd7);
      step(1);
      check("go_to_start", 32'(screen), 32'd0);
      step(5);
      check("held_single", 32'(screen), 32'd0);
      start_button = 1'b1;
      step(3);

      // Win through all levels.
      do_press();
      check("g2_screen", 32'(screen), 32'd1);
      check("g2_lives", 32'(lives), 32'd2);
      measure_hold(n);
      win_step(3'b001);
      check("w1_screen", 32'(screen), 32'd2);
      measure_hold(n);
      check("w1_hold", 32'(n), 32'd3);
      win_step(3'b010);
      check("w2_screen", 32'(screen), 32'd3);
      measure_hold(n);
      check("w2_hold", 32'(n), 32'd3);
      win_step(3'b100);
      check("w3_screen", 32'(screen), 32'd6);
      check("w3_lrn", 32'(level_reset_n), 32'd1);
      check("w3_lives", 32'(lives), 32'd2);
      do_press();
      check("win_to_start", 32'(screen), 32'd0);
      step(3);

      // Non-current lose ignored; simultaneous win+lose takes the win.
      do_press();
      measure_hold(n);
      level_lose = 3'b100;
      step(1);
      level_lose = 3'b000;
      check("ign_screen", 32'(screen), 32'd1);
      check("ign_lives", 32'(lives), 32'd2);
      check("ign_lrn", 32'(level_reset_n), 32'd1);
      level_win  = 3'b001;
      level_lose = 3'b001;
      step(1);
      level_win  = 3'b000;
      level_lose = 3'b000;
      check("both_screen", 32'(screen), 32'd2);
      check("both_lives", 32'(lives), 32'd2);
      measure_hold(n);
      level_lose = 3'b010;
      step(1);
      level_lose = 3'b000;
      check("l2_lose_lives", 32'(lives), 32'd1);
      check("l2_lose_screen", 32'(screen), 32'd2);
      measure_hold(n);
      step(5);
      check("pre_rst_sec", seconds, 32'd1);

      // Asynchronous reset between clock edges.
      #2;
      reset = 1'b1;
      #1;
      check("arst_screen", 32'(screen), 32'd0);
      check("arst_lives", 32'(lives), 32'd2);
      check("arst_sec", seconds, 32'd2);
      check("arst_lrn", 32'(level_reset_n), 32'd0);
      check("arst_inen", 32'(inputs_enable), 32'd0);
      check("arst_leds", 32'(leds), 32'h3);
      step(1);
      reset = 1'b0;
      step(2);
      check("post_rst_screen", 32'(screen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
